// File: rtl/handshake_fork_eager_pkg.sv
// Shared defaults for the eager fork; all widths derive from these parameters.
package handshake_fork_eager_pkg;
  localparam int DEF_SIZE      = 2;
  localparam int DEF_DATA_TYPE = 32;
endpackage

// File: rtl/handshake_fork_eager_register_block.sv
// Per-channel state for the eager fork: remembers whether the current token
// has already been delivered on this channel.
module eager_fork_register_block (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic outs_ready,
  input  logic block_stop,
  output logic stop_upstream,
  output logic outs_valid
);
  logic r_sent;
  logic w_xfer;

  assign outs_valid    = ins_valid & ~r_sent;
  assign w_xfer        = outs_valid & outs_ready;
  assign stop_upstream = ~(r_sent | outs_ready);

  // Retirement of the token wins over a same-cycle transfer so the next token starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent <= 1'b0;
    end else if (ins_valid & ~block_stop) begin
      r_sent <= 1'b0;
    end else begin
      r_sent <= r_sent | w_xfer;
    end
  end
endmodule

// File: rtl/handshake_fork_eager.sv
// Eager fork: one input token replicated to SIZE channels, each firing on its
// own ready; the input is acknowledged once every channel has taken the token.
module handshake_fork_eager
  import handshake_fork_eager_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int DATA_TYPE = DEF_DATA_TYPE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);
  logic [SIZE-1:0] w_stop_upstream;
  logic [SIZE-1:0] w_done;
  logic            w_block_stop;

  assign w_done       = ~w_stop_upstream;
  assign ins_ready    = &w_done;
  assign w_block_stop = ~ins_ready;
  assign outs         = {SIZE{ins}};

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_chan
    eager_fork_register_block u_reg (
      .clk           (clk),
      .rst           (rst),
      .ins_valid     (ins_valid),
      .outs_ready    (outs_ready[gi]),
      .block_stop    (w_block_stop),
      .stop_upstream (w_stop_upstream[gi]),
      .outs_valid    (outs_valid[gi])
    );
  end
endmodule

// File: tb/tb_handshake_fork_eager.sv
// Bench for the eager fork: directed cases on SIZE=2/3 instances, a scored
// random-backpressure run on SIZE=4 and a per-cycle check of the SIZE=1 wire case.
module tb_handshake_fork_eager;
  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  // SIZE=2, 32-bit
  logic [31:0] d2_ins;
  logic        d2_valid, d2_ins_ready;
  logic [63:0] d2_outs;
  logic [1:0]  d2_ov, d2_ready;
  // SIZE=3, 8-bit
  logic [7:0]  d3_ins;
  logic        d3_valid, d3_ins_ready;
  logic [23:0] d3_outs;
  logic [2:0]  d3_ov, d3_ready;
  // SIZE=4, 16-bit
  logic [15:0] d4_ins;
  logic        d4_valid, d4_ins_ready;
  logic [63:0] d4_outs;
  logic [3:0]  d4_ov, d4_ready;
  // SIZE=1, 8-bit
  logic [7:0]  d1_ins;
  logic        d1_valid, d1_ins_ready;
  logic [7:0]  d1_outs;
  logic [0:0]  d1_ov, d1_ready;

  logic [15:0] exp_q[4][$];

  handshake_fork_eager #(.SIZE(2), .DATA_TYPE(32)) u_d2 (
    .clk(clk), .rst(rst), .ins(d2_ins), .ins_valid(d2_valid), .ins_ready(d2_ins_ready),
    .outs(d2_outs), .outs_valid(d2_ov), .outs_ready(d2_ready));
  handshake_fork_eager #(.SIZE(3), .DATA_TYPE(8)) u_d3 (
    .clk(clk), .rst(rst), .ins(d3_ins), .ins_valid(d3_valid), .ins_ready(d3_ins_ready),
    .outs(d3_outs), .outs_valid(d3_ov), .outs_ready(d3_ready));
  handshake_fork_eager #(.SIZE(4), .DATA_TYPE(16)) u_d4 (
    .clk(clk), .rst(rst), .ins(d4_ins), .ins_valid(d4_valid), .ins_ready(d4_ins_ready),
    .outs(d4_outs), .outs_valid(d4_ov), .outs_ready(d4_ready));
  handshake_fork_eager #(.SIZE(1), .DATA_TYPE(8)) u_d1 (
    .clk(clk), .rst(rst), .ins(d1_ins), .ins_valid(d1_valid), .ins_ready(d1_ins_ready),
    .outs(d1_outs), .outs_valid(d1_ov), .outs_ready(d1_ready));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver helpers: inputs change 1 time unit after the rising edge
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_slot();
    @(negedge clk);
  endtask

  initial begin
    int          cnt3[3];
    int          got4[4];
    int          retired;
    int          cycles;
    logic        presenting;
    logic [15:0] tok;
    logic [15:0] next_tok;
    logic [15:0] exp_v;

    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    d2_ins = '0; d2_valid = 1'b0; d2_ready = '0;
    d3_ins = '0; d3_valid = 1'b0; d3_ready = '0;
    d4_ins = '0; d4_valid = 1'b0; d4_ready = '0;
    d1_ins = '0; d1_valid = 1'b0; d1_ready = '0;

    // reset state
    repeat (2) drive_slot();
    sample_slot();
    check("rst_ov_d2", 64'(d2_ov), 64'h0);
    check("rst_ready_d2_none", 64'(d2_ins_ready), 64'h0);
    d2_ready = 2'b11;
    #1 check("rst_ready_d2_all", 64'(d2_ins_ready), 64'h1);
    d2_ready = 2'b00;
    drive_slot();
    rst = 1'b0;

    // reset mid-token with sent=01
    drive_slot();
    d2_valid = 1'b1; d2_ins = 32'h0000_1234; d2_ready = 2'b01;
    sample_slot();
    check("mid_ov_first", 64'(d2_ov), 64'h3);
    check("mid_ir_first", 64'(d2_ins_ready), 64'h0);
    drive_slot();
    d2_ready = 2'b00;
    sample_slot();
    check("mid_ov_sent01", 64'(d2_ov), 64'h2);
    #2 rst = 1'b1;
    #1 check("mid_rst_async_clear", 64'(d2_ov), 64'h3);
    d2_ready = 2'b11;
    #1 check("mid_rst_ir", 64'(d2_ins_ready), 64'h1);
    d2_ready = 2'b00;
    drive_slot();
    rst = 1'b0;
    sample_slot();
    check("post_rst_ov", 64'(d2_ov), 64'h3);
    drive_slot();
    d2_valid = 1'b0;

    // all ready in one cycle
    drive_slot();
    d2_valid = 1'b1; d2_ins = 32'hDEADBEEF; d2_ready = 2'b11;
    sample_slot();
    check("all_ov", 64'(d2_ov), 64'h3);
    check("all_ch0", 64'(d2_outs[31:0]), 64'hDEADBEEF);
    check("all_ch1", 64'(d2_outs[63:32]), 64'hDEADBEEF);
    check("all_ir", 64'(d2_ins_ready), 64'h1);
    drive_slot();
    d2_valid = 1'b0; d2_ready = 2'b00;
    sample_slot();
    check("all_after_ov", 64'(d2_ov), 64'h0);

    // staggered readiness on SIZE=3
    for (int c = 0; c < 3; c++) cnt3[c] = 0;
    drive_slot();
    d3_valid = 1'b1; d3_ins = 8'h5A; d3_ready = 3'b001;
    sample_slot();
    check("stag1_ov", 64'(d3_ov), 64'h7);
    check("stag1_ir", 64'(d3_ins_ready), 64'h0);
    check("stag1_data", 64'(d3_outs), 64'h5A5A5A);
    for (int c = 0; c < 3; c++) cnt3[c] += int'(d3_ov[c] & d3_ready[c]);
    drive_slot();
    d3_ready = 3'b100;
    sample_slot();
    check("stag2_ov", 64'(d3_ov), 64'h6);
    check("stag2_ir", 64'(d3_ins_ready), 64'h0);
    for (int c = 0; c < 3; c++) cnt3[c] += int'(d3_ov[c] & d3_ready[c]);
    drive_slot();
    d3_ready = 3'b010;
    sample_slot();
    check("stag3_ov", 64'(d3_ov), 64'h2);
    check("stag3_ir", 64'(d3_ins_ready), 64'h1);
    for (int c = 0; c < 3; c++) cnt3[c] += int'(d3_ov[c] & d3_ready[c]);
    drive_slot();
    d3_ready = 3'b111;
    d3_ins = 8'hC3;
    sample_slot();
    check("stag_next_ov", 64'(d3_ov), 64'h7);
    for (int c = 0; c < 3; c++) check($sformatf("stag_xfers_ch%0d", c), 64'(cnt3[c]), 64'h1);
    drive_slot();
    d3_valid = 1'b0; d3_ready = 3'b000;

    // back-to-back tokens 0..7
    for (int k = 0; k < 8; k++) begin
      drive_slot();
      d2_valid = 1'b1; d2_ins = 32'(k); d2_ready = 2'b11;
      sample_slot();
      check($sformatf("b2b_ir_%0d", k), 64'(d2_ins_ready), 64'h1);
      check($sformatf("b2b_ov_%0d", k), 64'(d2_ov), 64'h3);
      check($sformatf("b2b_ch0_%0d", k), 64'(d2_outs[31:0]), 64'(k));
      check($sformatf("b2b_ch1_%0d", k), 64'(d2_outs[63:32]), 64'(k));
    end
    drive_slot();
    d2_valid = 1'b0; d2_ready = 2'b00;

    // random backpressure on SIZE=4 with scoreboard
    presenting = 1'b0;
    tok        = '0;
    next_tok   = 16'h0100;
    retired    = 0;
    cycles     = 0;
    for (int c = 0; c < 4; c++) got4[c] = 0;
    while (retired < 1000 && cycles < 20000) begin
      drive_slot();
      cycles++;
      if (!presenting && next_tok < 16'h0100 + 16'd1000 && $urandom_range(0, 3) != 0) begin
        presenting = 1'b1;
        tok        = next_tok;
        next_tok   = next_tok + 16'd1;
        for (int c = 0; c < 4; c++) exp_q[c].push_back(tok);
      end
      d4_valid = presenting;
      d4_ins   = presenting ? tok : 16'($urandom_range(0, 65535));
      d4_ready = 4'($urandom_range(0, 15));
      sample_slot();
      for (int c = 0; c < 4; c++) begin
        if (d4_ov[c] && d4_ready[c]) begin
          got4[c]++;
          if (exp_q[c].size() == 0) begin
            check($sformatf("rand_extra_ch%0d", c), 64'(d4_outs[c*16 +: 16]), 64'hFFFF_FFFF);
          end else begin
            exp_v = exp_q[c].pop_front();
            check($sformatf("rand_data_ch%0d", c), 64'(d4_outs[c*16 +: 16]), 64'(exp_v));
          end
        end
      end
      if (d4_valid && d4_ins_ready) begin
        presenting = 1'b0;
        retired++;
      end
    end
    drive_slot();
    d4_valid = 1'b0; d4_ready = 4'b0000;
    check("rand_retired", 64'(retired), 64'd1000);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rand_count_ch%0d", c), 64'(got4[c]), 64'd1000);
      check($sformatf("rand_left_ch%0d", c), 64'(exp_q[c].size()), 64'd0);
    end

    // degenerate SIZE=1: a wire every cycle
    presenting = 1'b0;
    for (int n = 0; n < 300; n++) begin
      drive_slot();
      if (!presenting && $urandom_range(0, 1) == 1) begin
        presenting = 1'b1;
        d1_ins     = 8'($urandom_range(0, 255));
      end
      d1_valid = presenting;
      d1_ready = 1'($urandom_range(0, 1));
      sample_slot();
      check("deg_ir", 64'(d1_ins_ready), 64'(d1_ready[0]));
      check("deg_ov", 64'(d1_ov[0]), 64'(d1_valid));
      check("deg_data", 64'(d1_outs), 64'(d1_ins));
      if (d1_valid && d1_ins_ready) presenting = 1'b0;
    end
    drive_slot();
    d1_valid = 1'b0; d1_ready = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/handshake_fork_eager.md
# handshake_fork_eager

Eager fork for the dataflow handshake library: accepts one token on `ins` and replicates it to `SIZE` output channels. Each output fires independently, as soon as its own consumer is ready. The input is acknowledged only after every output has taken the token. It is the dual of the join used at the input of two-operand units such as comparators: it distributes one producer's result (for example a `cmpi` condition bit) to several consumers without deadlock or duplication.

## Interface
Parameters:
- `SIZE`, default 2: number of output channels, ≥ 1.
- `DATA_TYPE`, default 32: token data width in bits, ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all per-output state.
- `ins`  in  DATA_TYPE  input token data.
- `ins_valid`  in  1  input token present.
- `ins_ready`  out  1  input token consumed this cycle.
- `outs`  out  SIZE*DATA_TYPE  replicated data; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- `outs_valid`  out  SIZE  per-channel valid.
- `outs_ready`  in  SIZE  per-channel ready.

## Operation
- State: one bit per output, `sent[i]`. It means the current input token has already been transferred on channel i.
- `outs` is `ins` replicated SIZE times, purely combinational. There is no data register.
- `outs_valid[i] = ins_valid & ~sent[i]`.
- `done[i] = sent[i] | outs_ready[i]`.
- `ins_ready = &done`.
- Per-channel transfer: `outs_valid[i] & outs_ready[i]` in the same cycle.
- Next-state logic, per channel:
  - If `ins_valid & ins_ready`, then `sent[i] <= 0`. The token is retired and the next token starts fresh.
  - Else, `sent[i] <= sent[i] | (outs_valid[i] & outs_ready[i])`.
- While `ins_valid=0`, `sent` holds its value. In legal operation `sent` is all-zero whenever `ins_valid` is low, because upstream never withdraws a token.
- Each token is delivered exactly once per channel. No channel sees a token twice, and no channel is skipped.
- `SIZE=1`: degenerates to a wire. `outs_valid=ins_valid`, `ins_ready=outs_ready`, and `sent` never sets.

## Timing
- Zero-cycle latency. Valid, data and ready paths are combinational.
- There is a combinational `outs_ready` → `ins_ready` path. There is no valid → ready path inside this block.
- All outputs ready in the same cycle: the token is transferred on every channel and acknowledged in that cycle, and `sent` stays 0.
- Staggered readiness:
  - A channel that transfers early sets `sent[i]` on the next edge.
  - Its valid then drops while the remaining channels still hold valid.
  - `ins_ready` rises in the cycle the last pending channel is ready.
- Back-to-back tokens: after retirement, the next token is presented to all channels in the following cycle. Throughput is one token per cycle when all consumers are ready.
- Simultaneous final transfer and retirement: clearing takes priority over setting, so `sent` returns to 0.
- Reset:
  - Asynchronous assertion forces `sent` to 0 immediately.
  - During reset, `outs_valid` follows `ins_valid` and `ins_ready = &outs_ready`. There are no other registered outputs.
  - Reset mid-token clears progress. This is legal only because the whole circuit resets together.

## Structure
- No shared package content is needed. Widths are derived from parameters only.
- Sub-module `eager_fork_register_block`, instantiated once per channel in a generate loop.
  - Ports: `clk`, `rst`, `ins_valid`, `outs_ready`, `block_stop` (equals `~ins_ready`), `stop_upstream` (equals `~done[i]`), `outs_valid`.
  - It holds a single `sent` flop.
- The top level performs the AND-reduction over `done` and the data replication.

## Test plan
- **Reset:** assert `rst` mid-token, with `sent=2'b01` (SIZE=2). Required: `sent` clears immediately, and after release both `outs_valid` bits equal `ins_valid`.
- **All ready:** SIZE=2, DATA_TYPE=32, `ins=32'hDEADBEEF`, `ins_valid=1`, `outs_ready=2'b11`. Required: `outs_valid=2'b11` and both channels carry `32'hDEADBEEF` in the same cycle, with `ins_ready=1`.
- **Staggered:** SIZE=3, `outs_ready` = 3'b001, then 3'b100, then 3'b010 on consecutive cycles.
  - Required: `outs_valid` = 3'b111, then 3'b110, then 3'b010.
  - Required: `ins_ready=1` only in cycle 3, and each channel has exactly one transfer.
- **Back-to-back:** 8 tokens with values 0..7, all outputs always ready. Required: 8 tokens retired in 8 cycles, in order on every channel.
- **Random backpressure:** SIZE=4, 1000 tokens, random `outs_ready` and random `ins_valid` gaps. The scoreboard requires each channel to receive the exact input sequence with no duplicates or losses.
- **Degenerate case:** SIZE=1, random traffic. Required: `ins_ready == outs_ready[0]` and `outs_valid[0] == ins_valid` every cycle.
